// File: rtl/nrisc_mem_arbiter.sv
// nrisc_mem_arbiter: shares the single-ported NRISC memory between instruction
// fetch (if), core data access (dm) and the debug/loader port (dbg).
// Fixed priority dbg > dm > if, with a starvation guard that forces a fetch
// grant after STARVE_MAX consecutive dm/dbg grants while a fetch is pending.
// One access in flight: IDLE -> ACCESS (MEM_LAT cycles) -> RESP (ack) -> IDLE.
module nrisc_mem_arbiter #(
    parameter int AW         = 8,
    parameter int DW         = 8,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic          c,
    input  logic          rst_n,
    input  logic          halt,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_ack,
    output logic [DW-1:0] dm_rdata,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_ack,
    output logic [DW-1:0] dbg_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_read,
    output logic          mem_write,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic [1:0]    grant
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_IF   = 2'b01;
    localparam logic [1:0] GNT_DM   = 2'b10;
    localparam logic [1:0] GNT_DBG  = 2'b11;

    localparam logic [2:0] LAT_LAST   = 3'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_TOP = 4'(STARVE_MAX);

    state_e          state_q, state_d;
    logic [2:0]      lat_cnt_q, lat_cnt_d;
    logic [3:0]      starve_cnt_q, starve_cnt_d;
    logic [1:0]      gnt_q, gnt_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            mem_read_q, mem_read_d;
    logic            mem_write_q, mem_write_d;
    logic            if_ack_q, if_ack_d;
    logic            dm_ack_q, dm_ack_d;
    logic            dbg_ack_q, dbg_ack_d;
    logic [DW-1:0]   if_rdata_q, if_rdata_d;
    logic [DW-1:0]   dm_rdata_q, dm_rdata_d;
    logic [DW-1:0]   dbg_rdata_q, dbg_rdata_d;
    logic            busy_q, busy_d;
    logic            if_ok_s;
    logic [1:0]      sel_s;

    // Next-state, request selection, access sequencing and strobe generation.
    always_comb begin
        state_d      = state_q;
        lat_cnt_d    = lat_cnt_q;
        starve_cnt_d = starve_cnt_q;
        gnt_d        = gnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        if_ack_d     = 1'b0;
        dm_ack_d     = 1'b0;
        dbg_ack_d    = 1'b0;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;
        dbg_rdata_d  = dbg_rdata_q;
        if_ok_s      = if_req && !halt;
        sel_s        = GNT_NONE;

        case (state_q)
            ST_IDLE: begin
                // A starved fetch overrides the fixed priority order.
                if (if_ok_s && (starve_cnt_q == STARVE_TOP)) begin
                    sel_s = GNT_IF;
                end else if (dbg_req) begin
                    sel_s = GNT_DBG;
                end else if (dm_req) begin
                    sel_s = GNT_DM;
                end else if (if_ok_s) begin
                    sel_s = GNT_IF;
                end else begin
                    sel_s = GNT_NONE;
                end
                gnt_d = sel_s;

                case (sel_s)
                    GNT_IF: begin
                        addr_d  = if_addr;
                        we_d    = 1'b0;
                        wdata_d = {DW{1'b0}};
                    end
                    GNT_DM: begin
                        addr_d  = dm_addr;
                        we_d    = dm_we;
                        wdata_d = dm_wdata;
                    end
                    GNT_DBG: begin
                        addr_d  = dbg_addr;
                        we_d    = dbg_we;
                        wdata_d = dbg_wdata;
                    end
                    default: begin
                        addr_d  = addr_q;
                        we_d    = we_q;
                        wdata_d = wdata_q;
                    end
                endcase

                if (sel_s != GNT_NONE) begin
                    state_d     = ST_ACCESS;
                    lat_cnt_d   = 3'd0;
                    mem_read_d  = !we_d;
                    mem_write_d = we_d;
                end else begin
                    state_d = ST_IDLE;
                end

                // Count dm/dbg grants that bypass a waiting fetch.
                if (sel_s == GNT_IF) begin
                    starve_cnt_d = 4'd0;
                end else if ((sel_s != GNT_NONE) && if_ok_s) begin
                    starve_cnt_d = (starve_cnt_q == STARVE_TOP) ? STARVE_TOP
                                                                : starve_cnt_q + 4'd1;
                end else if (!if_req) begin
                    starve_cnt_d = 4'd0;
                end else begin
                    starve_cnt_d = starve_cnt_q;
                end
            end

            ST_ACCESS: begin
                if (lat_cnt_q == LAT_LAST) begin
                    state_d   = ST_RESP;
                    lat_cnt_d = 3'd0;
                    case (gnt_q)
                        GNT_IF: begin
                            if_ack_d   = 1'b1;
                            if_rdata_d = we_q ? if_rdata_q : mem_rdata;
                        end
                        GNT_DM: begin
                            dm_ack_d   = 1'b1;
                            dm_rdata_d = we_q ? dm_rdata_q : mem_rdata;
                        end
                        GNT_DBG: begin
                            dbg_ack_d   = 1'b1;
                            dbg_rdata_d = we_q ? dbg_rdata_q : mem_rdata;
                        end
                        default: begin
                            if_ack_d = 1'b0;
                        end
                    endcase
                end else begin
                    lat_cnt_d   = lat_cnt_q + 3'd1;
                    mem_read_d  = !we_q;
                    mem_write_d = we_q;
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
                gnt_d   = GNT_NONE;
            end

            default: begin
                state_d = ST_IDLE;
                gnt_d   = GNT_NONE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs; reset aborts any access in flight.
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            lat_cnt_q    <= 3'd0;
            starve_cnt_q <= 4'd0;
            gnt_q        <= GNT_NONE;
            we_q         <= 1'b0;
            addr_q       <= {AW{1'b0}};
            wdata_q      <= {DW{1'b0}};
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            if_ack_q     <= 1'b0;
            dm_ack_q     <= 1'b0;
            dbg_ack_q    <= 1'b0;
            if_rdata_q   <= {DW{1'b0}};
            dm_rdata_q   <= {DW{1'b0}};
            dbg_rdata_q  <= {DW{1'b0}};
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            lat_cnt_q    <= lat_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            gnt_q        <= gnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            if_ack_q     <= if_ack_d;
            dm_ack_q     <= dm_ack_d;
            dbg_ack_q    <= dbg_ack_d;
            if_rdata_q   <= if_rdata_d;
            dm_rdata_q   <= dm_rdata_d;
            dbg_rdata_q  <= dbg_rdata_d;
            busy_q       <= busy_d;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign if_ack    = if_ack_q;
    assign dm_ack    = dm_ack_q;
    assign dbg_ack   = dbg_ack_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign dbg_rdata = dbg_rdata_q;
    assign busy      = busy_q;
    assign grant     = gnt_q;

endmodule

// File: tb/tb_nrisc_mem_arbiter.sv
// Directed testbench for nrisc_mem_arbiter (MEM_LAT=1, STARVE_MAX=4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_nrisc_mem_arbiter;

    logic       c = 1'b0;
    logic       rst_n, halt;
    logic       if_req, dm_req, dm_we, dbg_req, dbg_we;
    logic [7:0] if_addr, dm_addr, dm_wdata, dbg_addr, dbg_wdata;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0] if_rdata, dm_rdata, dbg_rdata;
    logic       if_ack, dm_ack, dbg_ack, mem_read, mem_write, busy;
    logic [1:0] grant;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:255];

    always #5 c = ~c;

    // Behavioural single-port memory: combinational read, write on rising edge.
    assign mem_rdata = mem[mem_addr];
    always @(posedge c) begin
        if (mem_write) mem[mem_addr] <= mem_wdata;
    end

    nrisc_mem_arbiter #(.AW(8), .DW(8), .MEM_LAT(1), .STARVE_MAX(4)) dut (
        .c(c), .rst_n(rst_n), .halt(halt),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_rdata(mem_rdata), .busy(busy), .grant(grant)
    );

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge c);
        rst_n = 1'b1;
        repeat (10) @(negedge c);
        checks++;
        if ({busy, grant, mem_read, mem_write} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got busy=%b grant=%b rd=%b wr=%b exp all 0", busy, grant, mem_read, mem_write);
        end
        checks++;
        if ({if_ack, dm_ack, dbg_ack} !== 3'b0) begin
            errors++;
            $display("FAIL reset_acks got %b exp 000", {if_ack, dm_ack, dbg_ack});
        end
        checks++;
        if ({if_rdata, dm_rdata, dbg_rdata, mem_addr, mem_wdata} !== 40'h0) begin
            errors++;
            $display("FAIL reset_data got %h exp 0", {if_rdata, dm_rdata, dbg_rdata, mem_addr, mem_wdata});
        end
    endtask

    task automatic test_fetch();
        @(negedge c);
        if_req = 1'b1; if_addr = 8'h05;
        @(negedge c);
        checks++;
        if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 8'h05 || grant !== 2'b01) begin
            errors++;
            $display("FAIL fetch_access got rd=%b wr=%b addr=%h gnt=%b exp 1 0 05 01", mem_read, mem_write, mem_addr, grant);
        end
        checks++;
        if (if_ack !== 1'b0) begin
            errors++;
            $display("FAIL fetch_early_ack got %b exp 0", if_ack);
        end
        @(negedge c);
        checks++;
        if (if_ack !== 1'b1 || mem_read !== 1'b0 || if_rdata !== 8'hA3) begin
            errors++;
            $display("FAIL fetch_resp got ack=%b rd=%b rdata=%h exp 1 0 a3", if_ack, mem_read, if_rdata);
        end
        if_req = 1'b0;
        @(negedge c);
        checks++;
        if (if_ack !== 1'b0 || busy !== 1'b0 || grant !== 2'b00) begin
            errors++;
            $display("FAIL fetch_idle got ack=%b busy=%b gnt=%b exp 0 0 00", if_ack, busy, grant);
        end
    endtask

    task automatic test_dm_write_read();
        @(negedge c);
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 8'h10; dm_wdata = 8'h5C;
        @(negedge c);
        checks++;
        if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 8'h10 || grant !== 2'b10) begin
            errors++;
            $display("FAIL dm_wr_access got wr=%b rd=%b addr=%h gnt=%b exp 1 0 10 10", mem_write, mem_read, mem_addr, grant);
        end
        dm_wdata = 8'h00; dm_addr = 8'hFF;
        #1;
        checks++;
        if (mem_wdata !== 8'h5C || mem_addr !== 8'h10) begin
            errors++;
            $display("FAIL dm_wr_latched got wdata=%h addr=%h exp 5c 10", mem_wdata, mem_addr);
        end
        @(negedge c);
        checks++;
        if (dm_ack !== 1'b1 || mem_write !== 1'b0 || dm_rdata !== 8'h00 || mem[16] !== 8'h5C) begin
            errors++;
            $display("FAIL dm_wr_resp got ack=%b wr=%b rdata=%h mem=%h exp 1 0 00 5c", dm_ack, mem_write, dm_rdata, mem[16]);
        end
        dm_we = 1'b0; dm_addr = 8'h10;
        repeat (2) @(negedge c);
        checks++;
        if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 8'h10) begin
            errors++;
            $display("FAIL dm_rd_access got rd=%b wr=%b addr=%h exp 1 0 10", mem_read, mem_write, mem_addr);
        end
        @(negedge c);
        checks++;
        if (dm_ack !== 1'b1 || dm_rdata !== 8'h5C) begin
            errors++;
            $display("FAIL dm_rd_resp got ack=%b rdata=%h exp 1 5c", dm_ack, dm_rdata);
        end
        dm_req = 1'b0;
        @(negedge c);
    endtask

    task automatic test_priority_starve();
        logic [1:0] exp_g [5];
        logic       got_ack;
        exp_g = '{2'b11, 2'b10, 2'b10, 2'b10, 2'b01};
        @(negedge c);
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h01;
        dm_req  = 1'b1; dm_we  = 1'b0; dm_addr  = 8'h02;
        if_req  = 1'b1; if_addr = 8'h03; halt = 1'b0;
        for (int g = 0; g < 5; g++) begin
            got_ack = 1'b0;
            for (int k = 0; k < 10 && !got_ack; k++) begin
                @(negedge c);
                if (dbg_ack || dm_ack || if_ack) got_ack = 1'b1;
            end
            checks++;
            if (!got_ack) begin
                errors++;
                $display("FAIL prio_timeout grant #%0d got no ack exp ack", g);
            end else begin
                checks++;
                if (grant !== exp_g[g]) begin
                    errors++;
                    $display("FAIL prio_order grant #%0d got %b exp %b", g, grant, exp_g[g]);
                end
                if (dbg_ack) dbg_req = 1'b0;
                if (if_ack) if_req = 1'b0;
            end
        end
        dm_req = 1'b0; dbg_req = 1'b0; if_req = 1'b0;
        repeat (2) @(negedge c);
    endtask

    task automatic test_halt();
        int n_if;
        int n_dm;
        logic got_ack;
        n_if = 0; n_dm = 0;
        mem[8'h20] = 8'h7E;
        @(negedge c);
        halt = 1'b1; if_req = 1'b1; if_addr = 8'h20;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 8'h02;
        for (int k = 0; k < 12; k++) begin
            @(negedge c);
            if (if_ack) n_if++;
            if (dm_ack) n_dm++;
        end
        checks++;
        if (n_if != 0 || n_dm != 4) begin
            errors++;
            $display("FAIL halt_block got if_acks=%0d dm_acks=%0d exp 0 4", n_if, n_dm);
        end
        dm_req = 1'b0; halt = 1'b0;
        got_ack = 1'b0;
        for (int k = 0; k < 10 && !got_ack; k++) begin
            @(negedge c);
            if (if_ack) got_ack = 1'b1;
        end
        checks++;
        if (!got_ack || if_rdata !== 8'h7E) begin
            errors++;
            $display("FAIL halt_release got ack=%b rdata=%h exp 1 7e", got_ack, if_rdata);
        end
        if_req = 1'b0;
        @(negedge c);
    endtask

    task automatic test_reset_mid_write();
        int n_ack;
        n_ack = 0;
        @(negedge c);
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 8'h30; dm_wdata = 8'h99;
        @(negedge c);
        checks++;
        if (mem_write !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre got wr=%b busy=%b exp 1 1", mem_write, busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_write !== 1'b0 || mem_read !== 1'b0) begin
            errors++;
            $display("FAIL rst_async got wr=%b rd=%b exp 0 0", mem_write, mem_read);
        end
        dm_req = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge c);
            if (dm_ack) n_ack++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge c);
            if (dm_ack) n_ack++;
        end
        checks++;
        if (n_ack != 0 || busy !== 1'b0 || grant !== 2'b00) begin
            errors++;
            $display("FAIL rst_after got acks=%0d busy=%b gnt=%b exp 0 0 00", n_ack, busy, grant);
        end
        checks++;
        if (mem[8'h30] !== 8'h00 || if_rdata !== 8'h00 || dm_rdata !== 8'h00) begin
            errors++;
            $display("FAIL rst_data got mem=%h if_rdata=%h dm_rdata=%h exp 00 00 00", mem[8'h30], if_rdata, dm_rdata);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[5] = 8'hA3;
        rst_n = 1'b0; halt = 1'b0;
        if_req = 1'b0; if_addr = 8'h00;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = 8'h00; dm_wdata = 8'h00;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 8'h00; dbg_wdata = 8'h00;
        test_reset();
        test_fetch();
        test_dm_write_read();
        test_priority_starve();
        test_halt();
        test_reset_mid_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
